axi4lite_apb_req_front: RTL

AXI4-Lite slave front end of the AXI4-Lite to APB bridge. It accepts AXI4-Lite read and write transactions, checks address range and strobes, and issues one request at a time on the STREQ/SWRT/SSEL/SADDR/SWDATA request interface of the downstream APB master. It observes the APB completion (PENABLE && PREADY) and returns the B or R response to the AXI master.

---
 rtl/bridge_pkg.sv | 21 ++
 rtl/axi4lite_apb_req_front_if.sv | 39 +++
 rtl/axi4lite_hold_reg.sv | 49 ++++
 rtl/axi4lite_apb_req_front.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to APB bridge front end.
package bridge_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int PROT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_RD_REQ,
    ST_WR_RESP,
    ST_RD_RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4lite_apb_req_front_if.sv
// AXI4-Lite slave channels plus the request/observe signals toward the APB master.
interface axi4lite_apb_req_front_if;
  import bridge_pkg::*;

  logic                AWVALID, AWREADY;
  logic [ADDR_W-1:0]   AWADDR;
  logic [PROT_W-1:0]   AWPROT;
  logic                WVALID, WREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [STRB_W-1:0]   WSTRB;
  logic                BVALID, BREADY;
  logic [1:0]          BRESP;
  logic                ARVALID, ARREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic [PROT_W-1:0]   ARPROT;
  logic                RVALID, RREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                STREQ, SWRT, SSEL;
  logic [ADDR_W-1:0]   SADDR;
  logic [DATA_W-1:0]   SWDATA;
  logic [DATA_W-1:0]   SRDATA;
  logic                PENABLE, PREADY, PSLVERR;

  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY, SRDATA, PENABLE, PREADY, PSLVERR,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP,
           STREQ, SWRT, SSEL, SADDR, SWDATA
  );

  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY, SRDATA, PENABLE, PREADY, PSLVERR,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP,
           STREQ, SWRT, SSEL, SADDR, SWDATA
  );

endinterface

// File: rtl/axi4lite_hold_reg.sv
// One-entry valid/ready holding register; the consumer empties it with clr.
module axi4lite_hold_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         clr,
  output logic         full,
  output logic [W-1:0] data
);

  logic         full_q, full_d;
  logic         active_q;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clr) begin
      full_d = 1'b0;
    end else if (in_valid && in_ready) begin
      full_d = 1'b1;
      data_d = in_data;
    end
  end

  // active_q keeps READY low while reset is applied and for the first edge after it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      full_q   <= full_d;
      active_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign in_ready = active_q && !full_q;
  assign full     = full_q;
  assign data     = data_q;

endmodule

// File: rtl/axi4lite_apb_req_front.sv
// AXI4-Lite slave front end: decodes, arbitrates and issues one APB request at a time,
// then returns the B or R response once the APB access completes.
module axi4lite_apb_req_front
  import bridge_pkg::*;
#(
  parameter logic [31:0] c_base_addr   = 32'h0000_0000,
  parameter logic [31:0] c_addr_size   = 32'h0001_0000,
  parameter bit          c_strict_strb = 1'b1
) (
  input logic                       PCLK,
  input logic                       PRESET,
  axi4lite_apb_req_front_if.slave   bus
);

  logic                       aw_full, w_full, ar_full;
  logic                       aw_clr, w_clr, ar_clr;
  logic [PROT_W+ADDR_W-1:0]   aw_data, ar_data;
  logic [STRB_W+DATA_W-1:0]   w_data;

  axi4lite_hold_reg #(.W(PROT_W+ADDR_W)) u_aw_hold (
    .clk(PCLK), .rst(PRESET), .in_valid(bus.AWVALID), .in_ready(bus.AWREADY),
    .in_data({bus.AWPROT, bus.AWADDR}), .clr(aw_clr), .full(aw_full), .data(aw_data));

  axi4lite_hold_reg #(.W(STRB_W+DATA_W)) u_w_hold (
    .clk(PCLK), .rst(PRESET), .in_valid(bus.WVALID), .in_ready(bus.WREADY),
    .in_data({bus.WSTRB, bus.WDATA}), .clr(w_clr), .full(w_full), .data(w_data));

  axi4lite_hold_reg #(.W(PROT_W+ADDR_W)) u_ar_hold (
    .clk(PCLK), .rst(PRESET), .in_valid(bus.ARVALID), .in_ready(bus.ARREADY),
    .in_data({bus.ARPROT, bus.ARADDR}), .clr(ar_clr), .full(ar_full), .data(ar_data));

  logic [ADDR_W-1:0] aw_addr, ar_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [STRB_W-1:0] w_strb;
  logic              unused_prot;

  assign aw_addr     = aw_data[ADDR_W-1:0];
  assign ar_addr     = ar_data[ADDR_W-1:0];
  assign w_wdata     = w_data[DATA_W-1:0];
  assign w_strb      = w_data[STRB_W+DATA_W-1:DATA_W];
  assign unused_prot = ^{aw_data[PROT_W+ADDR_W-1:ADDR_W], ar_data[PROT_W+ADDR_W-1:ADDR_W]};

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a - c_base_addr) < c_addr_size;
  endfunction

  state_e            state_q, state_d;
  logic              last_wr_q, last_wr_d;
  logic              swrt_q, swrt_d;
  logic [ADDR_W-1:0] saddr_q, saddr_d;
  logic [DATA_W-1:0] swdata_q, swdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
  logic              wr_pend, rd_pend, apb_done, in_req;

  assign wr_pend  = aw_full && w_full;
  assign rd_pend  = ar_full;
  assign apb_done = bus.PENABLE && bus.PREADY;
  assign in_req   = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ);

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    swrt_d    = swrt_q;
    saddr_d   = saddr_q;
    swdata_d  = swdata_q;
    rdata_d   = rdata_q;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    aw_clr    = 1'b0;
    w_clr     = 1'b0;
    ar_clr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // When both are pending, the type not served last goes first
        if (wr_pend && (!rd_pend || !last_wr_q)) begin
          if (!in_range(aw_addr)) begin
            state_d = ST_WR_RESP;
            bresp_d = RESP_DECERR;
            aw_clr  = 1'b1;
            w_clr   = 1'b1;
          end else if (c_strict_strb && (w_strb != {STRB_W{1'b1}})) begin
            state_d = ST_WR_RESP;
            bresp_d = RESP_SLVERR;
            aw_clr  = 1'b1;
            w_clr   = 1'b1;
          end else begin
            state_d  = ST_WR_REQ;
            saddr_d  = aw_addr;
            swdata_d = w_wdata;
            swrt_d   = 1'b1;
          end
        end else if (rd_pend) begin
          if (!in_range(ar_addr)) begin
            state_d = ST_RD_RESP;
            rresp_d = RESP_DECERR;
            ar_clr  = 1'b1;
          end else begin
            state_d = ST_RD_REQ;
            saddr_d = ar_addr;
            swrt_d  = 1'b0;
          end
        end
      end
      ST_WR_REQ: begin
        if (apb_done) begin
          state_d   = ST_WR_RESP;
          bresp_d   = bus.PSLVERR ? RESP_SLVERR : RESP_OKAY;
          aw_clr    = 1'b1;
          w_clr     = 1'b1;
          last_wr_d = 1'b1;
        end
      end
      ST_RD_REQ: begin
        if (apb_done) begin
          state_d   = ST_RD_RESP;
          rresp_d   = bus.PSLVERR ? RESP_SLVERR : RESP_OKAY;
          rdata_d   = bus.SRDATA;
          ar_clr    = 1'b1;
          last_wr_d = 1'b0;
        end
      end
      ST_WR_RESP: if (bus.BREADY) state_d = ST_IDLE;
      ST_RD_RESP: if (bus.RREADY) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= ST_IDLE;
      last_wr_q <= 1'b0;
      swrt_q    <= 1'b0;
      saddr_q   <= '0;
      swdata_q  <= '0;
      rdata_q   <= '0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      swrt_q    <= swrt_d;
      saddr_q   <= saddr_d;
      swdata_q  <= swdata_d;
      rdata_q   <= rdata_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
    end
  end

  // STREQ drops in the completion cycle so the APB master does not start a second Setup
  assign bus.SSEL   = in_req;
  assign bus.STREQ  = in_req && !apb_done;
  assign bus.SWRT   = swrt_q;
  assign bus.SADDR  = saddr_q;
  assign bus.SWDATA = swdata_q;
  assign bus.BVALID = (state_q == ST_WR_RESP);
  assign bus.BRESP  = bresp_q;
  assign bus.RVALID = (state_q == ST_RD_RESP);
  assign bus.RRESP  = rresp_q;
  assign bus.RDATA  = rdata_q;

endmodule
